// File: rtl/riscv_soft_host_arbiter.sv
`default_nettype none
// ============================================================================
// riscv_soft_host_arbiter: round-robin two-master arbiter for the tile host port.
// Optional WAIT watchdog enabled by macro RISCV_SOFT_HOST_ARB_TIMEOUT_EN. Rev 1.0
// ============================================================================
module riscv_soft_host_arbiter #(
  parameter int XPR_LEN        = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               reset,

  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [1:0]         req0_op,
  input  logic [2:0]         req0_op_type,
  input  logic [XPR_LEN-1:0] req0_addr,
  input  logic [XPR_LEN-1:0] req0_data,
  output logic               resp0_valid,
  output logic [XPR_LEN-1:0] resp0_data,
  output logic               resp0_err,

  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [1:0]         req1_op,
  input  logic [2:0]         req1_op_type,
  input  logic [XPR_LEN-1:0] req1_addr,
  input  logic [XPR_LEN-1:0] req1_data,
  output logic               resp1_valid,
  output logic [XPR_LEN-1:0] resp1_data,
  output logic               resp1_err,

  output logic               host_req_valid,
  input  logic               host_req_ready,
  output logic [1:0]         host_req_op,
  output logic [2:0]         host_req_op_type,
  output logic [XPR_LEN-1:0] host_req_addr,
  output logic [XPR_LEN-1:0] host_req_data,
  input  logic               host_resp_valid,
  input  logic [XPR_LEN-1:0] host_resp_data
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  logic [1:0]              state_q, state_d;
  logic                    prio_q, prio_d;
  logic                    owner_q, owner_d;
  logic [1:0]              op_q, op_d;
  logic [2:0]              op_type_q, op_type_d;
  logic [XPR_LEN-1:0]      addr_q, addr_d;
  logic [XPR_LEN-1:0]      data_q, data_d;
  logic [1:0]              resp_valid_q, resp_valid_d;
  logic [1:0]              resp_err_q, resp_err_d;
  logic [1:0][XPR_LEN-1:0] resp_data_q, resp_data_d;

  logic winner;
  logic handshake;
  logic resp_fire;
  logic timeout_fire;
  logic stale_drop;

  // Only a valid port can win; prio breaks the tie when both are valid.
  assign winner    = (req0_valid & req1_valid) ? prio_q : req1_valid;
  assign handshake = (state_q == ST_IDLE) & (req0_valid | req1_valid);
  assign resp_fire = (state_q == ST_WAIT) & host_resp_valid & ~stale_drop;

`ifdef RISCV_SOFT_HOST_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stale_q, stale_d;

  assign stale_drop   = host_resp_valid & stale_q;
  assign timeout_fire = (state_q == ST_WAIT) & ~resp_fire &
                        (cnt_q == CNT_W'(TIMEOUT_CYCLES));

  always_comb begin
    cnt_d   = cnt_q;
    stale_d = stale_q;
    if (state_q == ST_ISSUE) begin
      cnt_d = '0;
    end else if ((state_q == ST_WAIT) && (cnt_q != CNT_W'(TIMEOUT_CYCLES))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    // The abandoned transaction's response may still arrive; swallow exactly one.
    if (timeout_fire) begin
      stale_d = 1'b1;
    end else if (stale_drop) begin
      stale_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      stale_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      stale_q <= stale_d;
    end
  end
`else
  assign stale_drop   = 1'b0;
  assign timeout_fire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (handshake)                   state_d = ST_ISSUE;
      ST_ISSUE: if (host_req_ready)              state_d = ST_WAIT;
      ST_WAIT:  if (resp_fire || timeout_fire)   state_d = ST_IDLE;
      default:                                   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req0_ready     = 1'b0;
    req1_ready     = 1'b0;
    host_req_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req0_ready = req0_valid & ~winner;
        req1_ready = req1_valid & winner;
      end
      ST_ISSUE: host_req_valid = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    prio_d       = prio_q;
    owner_d      = owner_q;
    op_d         = op_q;
    op_type_d    = op_type_q;
    addr_d       = addr_q;
    data_d       = data_q;
    resp_valid_d = 2'b00;
    resp_err_d   = 2'b00;
    resp_data_d  = resp_data_q;
    if (handshake) begin
      owner_d   = winner;
      prio_d    = ~winner;
      op_d      = winner ? req1_op      : req0_op;
      op_type_d = winner ? req1_op_type : req0_op_type;
      addr_d    = winner ? req1_addr    : req0_addr;
      data_d    = winner ? req1_data    : req0_data;
    end
    if (resp_fire) begin
      resp_valid_d[owner_q] = 1'b1;
      resp_data_d[owner_q]  = host_resp_data;
    end else if (timeout_fire) begin
      resp_valid_d[owner_q] = 1'b1;
      resp_err_d[owner_q]   = 1'b1;
      resp_data_d[owner_q]  = XPR_LEN'(32'hDEADBEEF);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prio_q       <= 1'b0;
      owner_q      <= 1'b0;
      op_q         <= '0;
      op_type_q    <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      resp_valid_q <= '0;
      resp_err_q   <= '0;
      resp_data_q  <= '0;
    end else begin
      prio_q       <= prio_d;
      owner_q      <= owner_d;
      op_q         <= op_d;
      op_type_q    <= op_type_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_data_q  <= resp_data_d;
    end
  end

  assign host_req_op      = op_q;
  assign host_req_op_type = op_type_q;
  assign host_req_addr    = addr_q;
  assign host_req_data    = data_q;

  assign resp0_valid = resp_valid_q[0];
  assign resp1_valid = resp_valid_q[1];
  assign resp0_err   = resp_err_q[0];
  assign resp1_err   = resp_err_q[1];
  assign resp0_data  = resp_data_q[0];
  assign resp1_data  = resp_data_q[1];

endmodule
`default_nettype wire
